// File: rtl/cpu_controller.sv
// cpu_controller: multicycle fetch/decode/execute sequencer driving the alu/regfile cluster and one sync-read memory.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXECUTE); LOAD takes 4 (adds LOADWB).
// Backpressure: none; memory and regfile answer in fixed time, so the sequence never stalls.
module cpu_controller #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] mem_rdata,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic [3:0]  ra1,
   output logic [3:0]  ra2,
   output logic [3:0]  wa,
   output logic        regwrite,
   output logic [15:0] wd,
   input  logic [15:0] rd1,
   input  logic [15:0] rd2,
   output logic [15:0] alu_src,
   output logic [15:0] alu_dest,
   output logic [3:0]  aluop,
   output logic [3:0]  opext,
   input  logic [15:0] alu_result,
   input  logic [5:0]  alu_psr,
   output logic [5:0]  psr,
   output logic [15:0] pc,
   output logic        instr_done
);

   typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, LOADWB} state_t;

   state_t      state, state_nxt;
   logic [15:0] pc_q;
   logic [15:0] ir;
   logic [5:0]  psr_q;

   // Instruction field decode; everything below is a pure function of ir.
   logic [3:0]  opc, fn;
   logic        fn_alu, opc_alu;
   logic        is_rtype, is_cmp, is_imm, is_load, is_stor, is_br;
   logic        alu_class, alu_wr;
   logic [15:0] imm_ext;
   logic [3:0]  alu_op_dec;
   logic [15:0] br_target;
   logic        br_taken;

   assign opc = ir[15:12];
   assign fn  = ir[7:4];

   assign fn_alu  = (fn == 4'b0001) || (fn == 4'b0010) || (fn == 4'b0011) ||
                    (fn == 4'b0101) || (fn == 4'b1001);
   assign opc_alu = (opc == 4'b0001) || (opc == 4'b0010) || (opc == 4'b0011) ||
                    (opc == 4'b0101) || (opc == 4'b1001);

   assign is_rtype  = (opc == 4'b0000) && fn_alu;
   assign is_cmp    = (opc == 4'b0000) && (fn == 4'b1011);
   assign is_imm    = opc_alu || (opc == 4'b1011);
   assign is_load   = (opc == 4'b0100) && (fn == 4'b0000);
   assign is_stor   = (opc == 4'b0100) && (fn == 4'b0100);
   assign is_br     = (opc == 4'b1100);
   assign alu_class = is_rtype || is_cmp || is_imm;
   // Compares (CMP, CMPI) update flags only.
   assign alu_wr    = is_rtype || opc_alu;

   // Logical immediates are zero-extended, arithmetic ones sign-extended.
   assign imm_ext = ((opc == 4'b0001) || (opc == 4'b0010) || (opc == 4'b0011)) ?
                    {8'h00, ir[7:0]} : {{8{ir[7]}}, ir[7:0]};

   // Compares map onto SUB; other ALU forms pass their op field straight through.
   assign alu_op_dec = is_rtype ? fn : (opc_alu ? opc : 4'b1001);

   // pc already points past the branch when EXECUTE runs, so the target is pc+disp.
   assign br_target = pc_q + {{8{ir[7]}}, ir[7:0]};

   assign ra1      = ir[3:0];
   assign ra2      = ir[11:8];
   assign wa       = ir[11:8];
   assign alu_dest = rd2;
   assign opext    = 4'b0000;
   assign psr      = psr_q;
   assign pc       = pc_q;

   // Branch condition evaluated against the latched flags.
   always_comb begin
      br_taken = 1'b0;
      case (ir[11:8])
         4'b0000: br_taken =  psr_q[3];
         4'b0001: br_taken = ~psr_q[3];
         4'b0010: br_taken =  psr_q[0];
         4'b0011: br_taken = ~psr_q[0];
         4'b0100: br_taken =  psr_q[2];
         4'b0101: br_taken = ~psr_q[2];
         4'b0110: br_taken =  psr_q[4];
         4'b0111: br_taken = ~psr_q[4];
         4'b1000: br_taken =  psr_q[1];
         4'b1001: br_taken = ~psr_q[1];
         4'b1110: br_taken = 1'b1;
         default: br_taken = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   // Architectural state: instruction latch, pc advance/branch, flag capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         ir    <= 16'h0000;
         psr_q <= 6'b000000;
      end else begin
         case (state)
            DECODE: begin
               ir   <= mem_rdata;
               pc_q <= pc_q + 16'd1;
            end
            EXECUTE: begin
               if (alu_class)          psr_q <= alu_psr;
               if (is_br && br_taken)  pc_q  <= br_target;
            end
            default: ;
         endcase
      end
   end

   // Next-state sequencing; only LOAD takes the extra write-back cycle.
   always_comb begin
      state_nxt = FETCH;
      case (state)
         FETCH:   state_nxt = DECODE;
         DECODE:  state_nxt = EXECUTE;
         EXECUTE: state_nxt = is_load ? LOADWB : FETCH;
         LOADWB:  state_nxt = FETCH;
         default: state_nxt = FETCH;
      endcase
   end

   // Per-state datapath controls; reset masks every write strobe in the same cycle.
   always_comb begin
      regwrite   = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = pc_q;
      mem_wdata  = rd2;
      alu_src    = is_imm ? imm_ext : rd1;
      aluop      = alu_class ? alu_op_dec : 4'b0000;
      wd         = alu_result;
      instr_done = 1'b0;
      case (state)
         EXECUTE: begin
            instr_done = ~is_load;
            if (is_load || is_stor) mem_addr = rd1;
            if (is_stor)            mem_we   = 1'b1;
            if (alu_wr)             regwrite = 1'b1;
         end
         LOADWB: begin
            wd         = mem_rdata;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         regwrite   = 1'b0;
         mem_we     = 1'b0;
         instr_done = 1'b0;
      end
   end

endmodule
